// File: rtl/game_tick_scheduler.sv
// rtl/game_tick_scheduler.sv - frame strobe and game-step req/ack scheduler for the snake core
// Optional feature macro: GAME_TICK_BOOST_EN adds i_boost, which halves (rounding up) the latched step period.
module game_tick_scheduler #(
   parameter int FRAME_DIV = 2320312,
   parameter int DIV_W     = 22,
   parameter int CNT_W     = 16
) (
   input  logic             i_clk_74M,
   input  logic             i_rst_n,
   input  logic             i_run,
   input  logic             i_pause,
   input  logic [3:0]       i_speed,
   input  logic             i_step_ack,
`ifdef GAME_TICK_BOOST_EN
   input  logic             i_boost,
`endif
   output logic             o_frame_tick,
   output logic             o_step_req,
   output logic             o_paused,
   output logic             o_overrun,
   output logic [CNT_W-1:0] o_step_cnt
);

   typedef enum logic [1:0] {IDLE, RUN, WAIT_ACK, PAUSED} state_t;

   localparam logic [DIV_W-1:0] FRAME_LAST = DIV_W'(FRAME_DIV - 1);

   state_t           state_q, state_d;
   logic [DIV_W-1:0] frame_cnt_q, frame_cnt_d;
   logic             frame_tick_q, frame_tick_d;
   logic [4:0]       step_div_q, step_div_d;
   logic [4:0]       period_q, period_d;
   logic             step_req_q, step_req_d;
   logic             paused_q, paused_d;
   logic             overrun_q, overrun_d;
   logic             pending_q, pending_d;
   logic [CNT_W-1:0] step_cnt_q, step_cnt_d;

   logic [4:0] base_period;
   logic [4:0] new_period;
   logic       active;
   logic       boundary;
   logic       ack;

   assign base_period = 5'd16 - {1'b0, i_speed};
`ifdef GAME_TICK_BOOST_EN
   assign new_period  = i_boost ? ((base_period + 5'd1) >> 1) : base_period;
`else
   assign new_period  = base_period;
`endif

   // frame_tick_q is high exactly while frame_cnt_q sits at FRAME_LAST
   assign active   = (state_q == RUN) || (state_q == WAIT_ACK);
   assign boundary = active && frame_tick_q && (step_div_q == period_q - 5'd1);
   assign ack      = i_step_ack && step_req_q;

   always_comb begin
      state_d      = state_q;
      frame_cnt_d  = (frame_cnt_q == FRAME_LAST) ? '0 : frame_cnt_q + DIV_W'(1);
      frame_tick_d = (frame_cnt_d == FRAME_LAST);
      step_div_d   = step_div_q;
      period_d     = period_q;
      step_req_d   = step_req_q;
      paused_d     = paused_q;
      overrun_d    = overrun_q;
      pending_d    = pending_q;
      step_cnt_d   = step_cnt_q;

      if (active && frame_tick_q) begin
         step_div_d = boundary ? 5'd0 : step_div_q + 5'd1;
      end
      if (boundary) begin
         period_d = new_period;
      end

      if (!i_run) begin
         state_d    = IDLE;
         step_req_d = 1'b0;
         paused_d   = 1'b0;
         pending_d  = 1'b0;
         step_div_d = 5'd0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d    = RUN;
               step_cnt_d = '0;
               overrun_d  = 1'b0;
               period_d   = new_period;
               step_div_d = 5'd0;
            end
            RUN: begin
               if (boundary) begin
                  state_d    = WAIT_ACK;
                  step_req_d = 1'b1;
               end else if (i_pause) begin
                  state_d  = PAUSED;
                  paused_d = 1'b1;
               end
            end
            WAIT_ACK: begin
               if (ack) begin
                  step_cnt_d = step_cnt_q + CNT_W'(1);
                  // a simultaneous boundary re-arms the request instead of dropping it
                  if (!boundary) begin
                     step_req_d = 1'b0;
                     if (pending_q) begin
                        state_d   = PAUSED;
                        paused_d  = 1'b1;
                        pending_d = 1'b0;
                     end else begin
                        state_d = RUN;
                     end
                  end
               end else if (boundary) begin
                  overrun_d = 1'b1;
               end else if (i_pause) begin
                  pending_d = 1'b1;
               end
            end
            PAUSED: begin
               step_req_d = 1'b0;
               if (i_pause) begin
                  state_d  = RUN;
                  paused_d = 1'b0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk_74M) begin
      if (!i_rst_n) begin
         state_q      <= IDLE;
         frame_cnt_q  <= '0;
         frame_tick_q <= 1'b0;
         step_div_q   <= 5'd0;
         period_q     <= 5'd0;
         step_req_q   <= 1'b0;
         paused_q     <= 1'b0;
         overrun_q    <= 1'b0;
         pending_q    <= 1'b0;
         step_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         frame_cnt_q  <= frame_cnt_d;
         frame_tick_q <= frame_tick_d;
         step_div_q   <= step_div_d;
         period_q     <= period_d;
         step_req_q   <= step_req_d;
         paused_q     <= paused_d;
         overrun_q    <= overrun_d;
         pending_q    <= pending_d;
         step_cnt_q   <= step_cnt_d;
      end
   end

   assign o_frame_tick = frame_tick_q;
   assign o_step_req   = step_req_q;
   assign o_paused     = paused_q;
   assign o_overrun    = overrun_q;
   assign o_step_cnt   = step_cnt_q;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// tb/tb_game_tick_scheduler.sv - directed bench for game_tick_scheduler with FRAME_DIV=4
module tb_game_tick_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        run;
   logic        pause;
   logic [3:0]  speed;
   logic        ack;
   logic        frame_tick;
   logic        step_req;
   logic        paused;
   logic        overrun;
   logic [15:0] step_cnt;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   game_tick_scheduler #(.FRAME_DIV(4), .DIV_W(2), .CNT_W(16)) dut (
      .i_clk_74M   (clk),
      .i_rst_n     (rst_n),
      .i_run       (run),
      .i_pause     (pause),
      .i_speed     (speed),
      .i_step_ack  (ack),
`ifdef GAME_TICK_BOOST_EN
      .i_boost     (1'b0),
`endif
      .o_frame_tick(frame_tick),
      .o_step_req  (step_req),
      .o_paused    (paused),
      .o_overrun   (overrun),
      .o_step_cnt  (step_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cycles(input int n);
      repeat (n) tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Lines up on a frame tick so the run edge lands with the frame counter at 0.
   task automatic start_run(input logic [3:0] spd);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (frame_tick === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      chk("align_frame_tick", {31'd0, found}, 32'd1);
      speed = spd;
      run   = 1'b1;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; run = 1'b0; pause = 1'b0; speed = 4'd0; ack = 1'b0;
      cycles(2);
      chk("rst_tick",    {31'd0, frame_tick}, 32'd0);
      chk("rst_req",     {31'd0, step_req},   32'd0);
      chk("rst_paused",  {31'd0, paused},     32'd0);
      chk("rst_overrun", {31'd0, overrun},    32'd0);
      chk("rst_cnt",     {16'd0, step_cnt},   32'd0);
      rst_n = 1'b1;

      // speed 15: one-frame period
      start_run(4'd15);
      chk("t1_e0_cnt", {16'd0, step_cnt}, 32'd0);
      cycles(3);
      chk("t1_e3_tick", {31'd0, frame_tick}, 32'd1);
      chk("t1_e3_req",  {31'd0, step_req},   32'd0);
      tick();
      chk("t1_e4_req",  {31'd0, step_req},   32'd1);
      chk("t1_e4_tick", {31'd0, frame_tick}, 32'd0);
      ack = 1'b1; tick(); ack = 1'b0;
      chk("t1_e5_req", {31'd0, step_req}, 32'd0);
      chk("t1_e5_cnt", {16'd0, step_cnt}, 32'd1);
      cycles(2);
      chk("t1_e7_tick", {31'd0, frame_tick}, 32'd1);
      tick();
      chk("t1_e8_req", {31'd0, step_req}, 32'd1);
      ack = 1'b1; tick(); ack = 1'b0;
      chk("t1_e9_cnt", {16'd0, step_cnt}, 32'd2);
      run = 1'b0; tick();
      chk("t1_idle_cnt_hold", {16'd0, step_cnt}, 32'd2);

      // speed 14: two-frame period, ack two cycles after each request
      start_run(4'd14);
      chk("t2_e0_cnt_cleared", {16'd0, step_cnt}, 32'd0);
      cycles(7);
      chk("t2_e7_req", {31'd0, step_req}, 32'd0);
      tick();
      chk("t2_e8_req", {31'd0, step_req}, 32'd1);
      for (int k = 0; k < 3; k++) begin
         tick();
         ack = 1'b1; tick(); ack = 1'b0;
         chk("t2_ack_req",     {31'd0, step_req}, 32'd0);
         chk("t2_ack_cnt",     {16'd0, step_cnt}, k + 1);
         chk("t2_ack_overrun", {31'd0, overrun},  32'd0);
         if (k < 2) begin
            cycles(5);
            chk("t2_before_req", {31'd0, step_req}, 32'd0);
            tick();
            chk("t2_req", {31'd0, step_req}, 32'd1);
         end
      end
      run = 1'b0; tick();

      // speed 15, no ack: second boundary flags overrun
      start_run(4'd15);
      cycles(4);
      chk("t3_e4_req", {31'd0, step_req}, 32'd1);
      cycles(3);
      chk("t3_e7_overrun", {31'd0, overrun}, 32'd0);
      tick();
      chk("t3_e8_overrun", {31'd0, overrun},  32'd1);
      chk("t3_e8_req",     {31'd0, step_req}, 32'd1);
      chk("t3_e8_cnt",     {16'd0, step_cnt}, 32'd0);
      cycles(4);
      chk("t3_e12_req",     {31'd0, step_req}, 32'd1);
      chk("t3_e12_overrun", {31'd0, overrun},  32'd1);

      run = 1'b0; tick();
      chk("t6_idle_req",          {31'd0, step_req}, 32'd0);
      chk("t6_idle_overrun_hold", {31'd0, overrun},  32'd1);

      // speed 12: four-frame period, pause after the first counted frame
      start_run(4'd12);
      chk("t6_rerun_overrun_cleared", {31'd0, overrun}, 32'd0);
      cycles(5);
      pause = 1'b1; tick(); pause = 1'b0;
      chk("t4_paused", {31'd0, paused}, 32'd1);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("t4_hold_req",    {31'd0, step_req}, 32'd0);
         chk("t4_hold_paused", {31'd0, paused},   32'd1);
      end
      pause = 1'b1; tick(); pause = 1'b0;
      chk("t4_resumed", {31'd0, paused}, 32'd0);
      cycles(8);
      chk("t4_e35_req", {31'd0, step_req}, 32'd0);
      tick();
      chk("t4_e36_req", {31'd0, step_req}, 32'd1);

      // pause while waiting for ack takes effect on the ack
      pause = 1'b1; tick(); pause = 1'b0;
      chk("t5_pending_paused", {31'd0, paused},   32'd0);
      chk("t5_pending_req",    {31'd0, step_req}, 32'd1);
      ack = 1'b1; tick(); ack = 1'b0;
      chk("t5_ack_paused", {31'd0, paused},   32'd1);
      chk("t5_ack_req",    {31'd0, step_req}, 32'd0);
      chk("t5_ack_cnt",    {16'd0, step_cnt}, 32'd1);
      cycles(6);
      chk("t5_still_paused", {31'd0, paused},   32'd1);
      chk("t5_no_req",       {31'd0, step_req}, 32'd0);
      run = 1'b0; tick();
      chk("t5_idle_paused",   {31'd0, paused},   32'd0);
      chk("t5_idle_cnt_hold", {16'd0, step_cnt}, 32'd1);

      // mid-run reset
      start_run(4'd15);
      chk("t6_rerun_cnt_cleared", {16'd0, step_cnt}, 32'd0);
      cycles(4);
      chk("t6_req", {31'd0, step_req}, 32'd1);
      rst_n = 1'b0; tick();
      chk("t6_rst_tick",    {31'd0, frame_tick}, 32'd0);
      chk("t6_rst_req",     {31'd0, step_req},   32'd0);
      chk("t6_rst_paused",  {31'd0, paused},     32'd0);
      chk("t6_rst_overrun", {31'd0, overrun},    32'd0);
      chk("t6_rst_cnt",     {16'd0, step_cnt},   32'd0);
      rst_n = 1'b1;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
